inst_fetch_queue: RTL and testbench
===================================

# inst_fetch_queue

Decoupled instruction fetch front-end for the 5-stage RISC-V pipeline. It generates sequential fetch addresses, issues them to an instruction memory port with variable latency, and buffers returned instructions in a small in-order queue. It presents {inst, PC, PC+4} to the IF/ID register with a valid/ready handshake. A redirect input (branch/jump resolved in MEM) flushes the queue and discards responses still in flight.

## Interface
- DEPTH, 4: queue entries and maximum outstanding requests; power of two, ≥2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-low.
- redirect_valid  in  1  branch/jump taken; flush and restart fetch.
- redirect_pc  in  32  new fetch address; bits [1:0] must be 0.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid; responses return in request order.
- imem_rsp_data  in  32  instruction word.
- out_valid  out  1  queue head valid.
- out_ready  in  1  IF/ID accepts head (low on stall).
- out_inst  out  32  head instruction.
- out_pc  out  32  head PC.
- out_pc_4  out  32  out_pc + 4, modulo 2^32.

## Operation
- State: fetch_pc (32b); queue of DEPTH entries {inst, pc} with head/tail pointers and count (0..DEPTH); inflight (0..DEPTH); drop (0..inflight).
- Request: imem_req_valid = rst & ~redirect_valid & (count + inflight < DEPTH). On req handshake: inflight++, fetch_pc += 4; 32-bit wrap, 32'hFFFF_FFFC → 0.
- imem_req_addr = fetch_pc. Addr held stable while valid & ~ready.
- Response: inflight--. If drop > 0: drop--, data discarded. Otherwise push {imem_rsp_data, pc of that request}. Push PC is tracked by a separate rsp_pc register advanced by 4 per kept response and loaded on redirect.
- Response with inflight == 0: ignored; protocol error, no state change.
- Pop: out_valid & out_ready removes head. Push and pop in the same cycle leave count unchanged. Credit rule guarantees no overflow. Pop on empty is impossible because out_valid = 0.
- Redirect (priority over everything):
  - count ← 0; fetch_pc, rsp_pc ← redirect_pc.
  - drop ← inflight minus any response arriving this cycle; that response is discarded regardless.
  - No request is issued this cycle.
  - out_valid is forced 0 this cycle. Any out_ready in that cycle is not a transfer.
- Back-to-back redirects: each reloads the PCs; drop accumulates to the current inflight.
- Reset (rst = 0 at edge): fetch_pc = rsp_pc = RESET_PC, count = inflight = drop = 0. Applies mid-operation. Memory responses to pre-reset requests are the memory's responsibility to cancel.

## Timing
- Reset values: imem_req_valid 0 (combinationally while rst = 0), imem_req_addr RESET_PC, out_valid 0, out_inst/out_pc 0, out_pc_4 4.
- First request: cycle after rst rises, addr RESET_PC.
- Latency, queue registered: request accepted cycle N, response cycle N+k (k ≥ 1), out_valid cycle N+k+1.
- Throughput: 1 instruction/cycle with single-cycle memory and out_ready high; DEPTH ≥ 2 sustains it.
- Redirect in cycle R: request to redirect_pc at R+1 earliest, out_valid at R+3 earliest with k = 1.

## Configuration
- Macro: FETCH_BYPASS_EN.
- Defined: when the queue is empty and a kept response arrives, head outputs show it combinationally the same cycle (out_valid = 1). If out_ready is also 1, it is consumed without being written; otherwise it is pushed. Latency drops by 1. Redirect still forces out_valid = 0.
- Undefined: outputs come only from queue registers; no combinational path from imem_rsp_* to out_*.

## Test plan
- Reset and stream: RESET_PC = 0, 1-cycle memory, out_ready = 1 → requests 0,4,8,…; out_pc 0,4,8 on consecutive cycles from cycle 3; out_pc_4 = out_pc + 4.
- Backpressure: out_ready = 0 for 10 cycles → exactly DEPTH = 4 entries are buffered and imem_req_valid drops. On release, 4 pops with out_pc 0,4,8,C, then requests resume at 10.
- Redirect with inflight: 3-cycle memory, 3 requests outstanding, redirect_pc = 0x100 → next 3 responses dropped; first out_pc = 0x100; count resets to 0.
- Redirect + response + pop in the same cycle → no transfer, response discarded, drop = inflight − 1, next out_pc = redirect_pc.
- Wrap: redirect to 0xFFFF_FFF8 → out_pc FFFF_FFF8, FFFF_FFFC, 0; out_pc_4 of FFFF_FFFC = 0.
- Mid-operation reset with a full queue: rst = 0 one cycle → out_valid 0 next cycle, first request addr RESET_PC. With FETCH_BYPASS_EN, out_valid rises the same cycle as the first response.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - decoupled instruction fetch front-end with in-order response queue
// Optional same-cycle response bypass to the head outputs: FETCH_BYPASS_EN.
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_4
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_S = (CW+1)'(DEPTH);

    logic [31:0]   fetch_pc_q;
    logic [31:0]   rsp_pc_q;
    logic [31:0]   inst_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] inflight_q;
    logic [CW-1:0] drop_q;

    logic credit_ok;
    logic req_fire;
    logic rsp_fire;
    logic rsp_keep;
    logic q_empty;
    logic push;
    logic pop;

    // Queue slots plus outstanding requests never exceed DEPTH, so a kept
    // response always finds room.
    assign credit_ok      = ({1'b0, count_q} + {1'b0, inflight_q}) < DEPTH_S;
    assign imem_req_valid = rst & ~redirect_valid & credit_ok;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign rsp_fire       = imem_rsp_valid & (inflight_q != '0);
    assign rsp_keep       = rsp_fire & (drop_q == '0) & ~redirect_valid;
    assign q_empty        = (count_q == '0);

`ifdef FETCH_BYPASS_EN
    logic bypass;
    assign bypass    = q_empty & rsp_keep;
    assign out_valid = ~redirect_valid & (~q_empty | bypass);
    assign out_inst  = bypass ? imem_rsp_data : inst_q[head_q];
    assign out_pc    = bypass ? rsp_pc_q : pc_q[head_q];
    // A bypassed word that is consumed immediately never occupies a slot.
    assign push      = rsp_keep & ~(bypass & out_ready);
`else
    assign out_valid = ~redirect_valid & ~q_empty;
    assign out_inst  = inst_q[head_q];
    assign out_pc    = pc_q[head_q];
    assign push      = rsp_keep;
`endif
    assign out_pc_4  = out_pc + 32'd4;
    assign pop       = out_valid & out_ready & ~q_empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (redirect_valid) begin
            // Everything still in flight is stale; a response landing now is
            // discarded directly instead of being counted in drop.
            fetch_pc_q <= redirect_pc;
            rsp_pc_q   <= redirect_pc;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            inflight_q <= inflight_q - CW'(rsp_fire);
            drop_q     <= inflight_q - CW'(rsp_fire);
        end else begin
            if (req_fire) begin
                fetch_pc_q <= fetch_pc_q + 32'd4;
            end
            inflight_q <= inflight_q + CW'(req_fire) - CW'(rsp_fire);
            if (rsp_fire && drop_q != '0) begin
                drop_q <= drop_q - CW'(1);
            end
            if (rsp_keep) begin
                rsp_pc_q <= rsp_pc_q + 32'd4;
            end
            if (push) begin
                inst_q[tail_q] <= imem_rsp_data;
                pc_q[tail_q]   <= rsp_pc_q;
                tail_q         <= tail_q + PW'(1);
            end
            if (pop) begin
                head_q <= head_q + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - directed bench for inst_fetch_queue with a variable-latency memory model
module tb_inst_fetch_queue;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
    localparam int LAT0 = 1;
`else
    localparam int LAT0 = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_pc_4;

    inst_fetch_queue #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc), .out_pc_4(out_pc_4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_pc4[$];
    int          pop_cyc[$];
    logic [31:0] req_addr[$];
    int          req_cyc[$];

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          lat = 1;
    int          base = 0;
    logic [31:0] exp_pc = RESET_PC;
    logic        obs_out_valid = 1'b0;
    logic        obs_req_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic clear_logs();
        pop_pc.delete(); pop_pc4.delete(); pop_cyc.delete();
        req_addr.delete(); req_cyc.delete();
    endtask

    // One clock cycle: drive memory response, observe at negedge+1, track handshakes.
    task automatic step();
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
        obs_out_valid = out_valid;
        obs_req_valid = imem_req_valid;
        if (out_valid === 1'b1) begin
            check("head_pc", out_pc, exp_pc);
            check("head_inst", out_inst, mem_word(exp_pc));
            check("head_pc4", out_pc_4, exp_pc + 32'd4);
            if (out_ready) begin
                pop_pc.push_back(out_pc);
                pop_pc4.push_back(out_pc_4);
                pop_cyc.push_back(cyc);
                exp_pc = exp_pc + 32'd4;
            end
        end
        if (imem_req_valid === 1'b1 && imem_req_ready) begin
            mq.push_back('{addr: imem_req_addr, due: cyc + lat});
            req_addr.push_back(imem_req_addr);
            req_cyc.push_back(cyc);
        end
        if (redirect_valid) exp_pc = redirect_pc;
        if (!rst) exp_pc = RESET_PC;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        mq.delete();
        step();
    endtask

    task automatic release_reset();
        rst = 1'b1;
        clear_logs();
        base = cyc;
    endtask

    initial begin
        // Reset values
        out_ready = 1'b1;
        do_reset();
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_pc4", out_pc_4, 32'd4);

        // Streaming with single-cycle memory
        lat = 1;
        release_reset();
        steps(8);
        check("st_first_req_cyc", 32'(req_cyc[0]), 32'(base));
        check("st_first_req_addr", req_addr[0], RESET_PC);
        check("st_first_pop_cyc", 32'(pop_cyc[0]), 32'(base + LAT0));
        check("st_pop0", pop_pc[0], 32'h0);
        check("st_pop1", pop_pc[1], 32'h4);
        check("st_pop2", pop_pc[2], 32'h8);
        check("st_pop2_cyc", 32'(pop_cyc[2]), 32'(base + LAT0 + 2));

        // Backpressure fills exactly DEPTH entries
        do_reset();
        out_ready = 1'b0;
        release_reset();
        steps(10);
        check("bp_nreq", 32'(req_addr.size()), 32'd4);
        check("bp_req_valid", 32'(obs_req_valid), 32'd0);
        check("bp_out_valid", 32'(obs_out_valid), 32'd1);
        out_ready = 1'b1;
        clear_logs();
        base = cyc;
        steps(6);
        check("bp_pop0", pop_pc[0], 32'h0);
        check("bp_pop1", pop_pc[1], 32'h4);
        check("bp_pop2", pop_pc[2], 32'h8);
        check("bp_pop3", pop_pc[3], 32'hC);
        check("bp_pop3_cyc", 32'(pop_cyc[3]), 32'(base + 3));
        check("bp_resume_addr", req_addr[0], 32'h10);
        check("bp_resume_cyc", 32'(req_cyc[0]), 32'(base + 1));

        // Redirect with three requests in flight
        do_reset();
        lat = 4;
        release_reset();
        steps(3);
        check("rd_inflight", 32'(req_addr.size()), 32'd3);
        clear_logs();
        base = cyc;
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        check("rd_no_req", 32'(obs_req_valid), 32'd0);
        steps(12);
        check("rd_req_addr", req_addr[0], 32'h100);
        check("rd_req_cyc", 32'(req_cyc[0]), 32'(base + 1));
        check("rd_pop0", pop_pc[0], 32'h100);
        check("rd_pop0_cyc", 32'(pop_cyc[0]), 32'(base + 1 + lat + LAT0 - 1));

        // Redirect coinciding with a response and a ready head
        do_reset();
        lat = 2;
        release_reset();
        steps(6);
        check("rr_pre_valid", 32'(obs_out_valid), 32'd1);
        clear_logs();
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        step();
        redirect_valid = 1'b0;
        check("rr_out_valid", 32'(obs_out_valid), 32'd0);
        check("rr_no_pop", 32'(pop_pc.size()), 32'd0);
        steps(8);
        check("rr_pop0", pop_pc[0], 32'h200);
        check("rr_pop1", pop_pc[1], 32'h204);

        // Address wrap
        lat = 1;
        clear_logs();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        steps(10);
        check("wr_pop0", pop_pc[0], 32'hFFFF_FFF8);
        check("wr_pop1", pop_pc[1], 32'hFFFF_FFFC);
        check("wr_pop2", pop_pc[2], 32'h0);
        check("wr_pc4", pop_pc4[1], 32'h0);

        // Mid-operation reset with a full queue
        out_ready = 1'b0;
        steps(8);
        check("mr_full_valid", 32'(obs_out_valid), 32'd1);
        check("mr_full_req", 32'(obs_req_valid), 32'd0);
        do_reset();
        out_ready = 1'b1;
        release_reset();
        step();
        check("mr_out_valid", 32'(obs_out_valid), 32'd0);
        steps(4);
        check("mr_req_addr", req_addr[0], RESET_PC);
        check("mr_req_cyc", 32'(req_cyc[0]), 32'(base));
        check("mr_pop0", pop_pc[0], RESET_PC);
        check("mr_pop0_cyc", 32'(pop_cyc[0]), 32'(base + LAT0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
